sig_segment_search: RTL and testbench
=====================================

// Module: sig_segment_search
// PURPOSE
//  Sequential segment locator for the piecewise-linear sigmoid datapath.
//  Takes one signed Q3.12 operand x and finds its PWL segment by binary search
//  over a fixed breakpoint table, using one signed fixed-point greater-than
//  compare per clock. The segment index then drives the slope/intercept lookup
//  and the multiply-add stage downstream.
// PARAMETERS
//  Q        12  fractional bits of x and of each breakpoint
//  N        16  total width of x: 1 sign, N-Q-1 integer, Q fraction
//  SEG_BITS 3   segment index width; 2**SEG_BITS segments, 2**SEG_BITS-1 breakpoints
// PORTS
//  clk        in   1         single clock, rising edge
//  rst        in   1         synchronous, active-high reset
//  in_valid   in   1         x is valid
//  in_ready   out  1         block can accept x
//  x          in   N         signed Q3.12 operand
//  out_valid  out  1         seg and x_out are valid
//  out_ready  in   1         downstream accepts the result
//  seg        out  SEG_BITS  segment index, 0..2**SEG_BITS-1
//  x_out      out  N         registered copy of the accepted x
//  sat_lo     out  1         seg == 0 (x at or below the lowest breakpoint)
//  sat_hi     out  1         seg == max (x above the highest breakpoint)
// BEHAVIOUR
//  Breakpoint table (default)
//   - bp[0..6] = -3,-2,-1,0,1,2,3 in Q3.12:
//     16'hD000, E000, F000, 0000, 1000, 2000, 3000.
//   - Ascending; generated internally, not a port.
//  Compare
//   - gt(a,b) is a signed two's-complement strict a > b.
//   - Equal values give 0.
//  Segment definition
//   - seg = number of breakpoints strictly below x.
//   - x equal to bp[i] lands in segment i.
//  Reset
//   - State goes to IDLE.
//   - in_ready=1 (IDLE); out_valid=0.
//   - seg=0, x_out=0, sat_lo=0, sat_hi=0.
//  FSM states
//   - IDLE: in_ready=1. in_valid&in_ready at an edge latches x, clears the
//     index, sets step=SEG_BITS-1, and moves to SEARCH.
//   - SEARCH: in_ready=0. Each edge: cand = idx | (1<<step);
//     if gt(x_reg, bp[cand-1]) then idx = cand.
//     If step==0, go to DONE; otherwise decrement step.
//     Takes exactly SEG_BITS edges.
//   - DONE: out_valid=1. seg, sat_lo and sat_hi are registered and stable.
//     out_valid&out_ready at an edge moves to IDLE and drops out_valid.
//  Latency and throughput
//   - out_valid rises SEG_BITS cycles after the acceptance edge.
//   - One result per SEG_BITS+2 cycles when out_ready is held high.
//  Backpressure
//   - While DONE and out_ready=0, all outputs hold.
//   - in_ready stays 0; new x is not accepted.
//  Boundary cases
//   - x=16'h8000 (most negative) -> seg 0, sat_lo=1.
//   - x=16'h7FFF -> seg 2**SEG_BITS-1, sat_hi=1.
//   - in_valid is ignored outside IDLE; x changes during SEARCH do not
//     affect the result.
//  Reset mid-operation
//   - rst during SEARCH or DONE aborts the search.
//   - All outputs return to reset values on the next edge.
//   - The pending result is discarded, never emitted.
// TESTING
//  - x=16'h0000 -> seg=3, sat_lo=0, sat_hi=0, out_valid exactly 3 cycles after accept.
//  - x=16'h0001 -> seg=4; x=16'hF000 (-1.0, equals bp[2]) -> seg=2.
//  - x=16'h8000 -> seg=0, sat_lo=1; x=16'h7FFF -> seg=7, sat_hi=1; x_out echoes x.
//  - out_ready=0 for 5 cycles in DONE -> seg/x_out/out_valid stable, in_ready=0,
//    a second in_valid is not taken until the result handshakes.
//  - rst pulsed on the 2nd SEARCH cycle -> next cycle out_valid=0, in_ready=1,
//    seg=0; no stale result appears later.
//  - Random sweep of 10k x values, back-to-back with out_ready=1 -> seg matches a
//    reference count of bp[i] < x, throughput one result per 5 cycles.

Source files
------------

// File: rtl/sig_segment_search_if.sv
// Handshake bus between the sigmoid front end and the PWL segment locator.
// Operand in with valid/ready, segment result out with valid/ready.
interface sig_segment_search_if #(
    parameter int unsigned N        = 16,
    parameter int unsigned SEG_BITS = 3
);
    logic                in_valid;
    logic                in_ready;
    logic [N-1:0]        x;
    logic                out_valid;
    logic                out_ready;
    logic [SEG_BITS-1:0] seg;
    logic [N-1:0]        x_out;
    logic                sat_lo;
    logic                sat_hi;

    modport master (
        output in_valid, x, out_ready,
        input  in_ready, out_valid, seg, x_out, sat_lo, sat_hi
    );

    modport slave (
        input  in_valid, x, out_ready,
        output in_ready, out_valid, seg, x_out, sat_lo, sat_hi
    );
endinterface

// File: rtl/sig_segment_search.sv
// Sequential PWL segment locator: binary search over an ascending breakpoint
// table, one signed compare per clock, SEG_BITS search cycles per operand.
module sig_segment_search #(
    parameter int unsigned Q        = 12,
    parameter int unsigned N        = 16,
    parameter int unsigned SEG_BITS = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    sig_segment_search_if.slave    bus
);
    localparam int unsigned NUM_BP = (2 ** SEG_BITS) - 1;
    localparam int unsigned HALF   = NUM_BP / 2;
    localparam int unsigned STEP_W = (SEG_BITS > 1) ? $clog2(SEG_BITS) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    // Breakpoints are integers centred on zero: bp[i] = (i - HALF) in Q format.
    function automatic logic signed [N-1:0] bp_at(input logic [SEG_BITS-1:0] i);
        int v;
        v = (int'(i) - int'(HALF)) * int'(2 ** Q);
        return N'(v);
    endfunction

    logic [1:0]          state_q,     state_d;
    logic signed [N-1:0] x_q,         x_d;
    logic [SEG_BITS-1:0] idx_q,       idx_d;
    logic [STEP_W-1:0]   step_q,      step_d;
    logic [SEG_BITS-1:0] seg_q,       seg_d;
    logic [N-1:0]        x_out_q,     x_out_d;
    logic                sat_lo_q,    sat_lo_d;
    logic                sat_hi_q,    sat_hi_d;
    logic                in_ready_q,  in_ready_d;
    logic                out_valid_q, out_valid_d;

    logic [SEG_BITS-1:0] cand;
    logic [SEG_BITS-1:0] idx_next;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        idx_d    = idx_q;
        step_d   = step_q;
        seg_d    = seg_q;
        x_out_d  = x_out_q;
        sat_lo_d = sat_lo_q;
        sat_hi_d = sat_hi_q;
        cand     = idx_q | (SEG_BITS'(1) << step_q);
        idx_next = idx_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    x_d     = bus.x;
                    idx_d   = '0;
                    step_d  = STEP_W'(SEG_BITS - 1);
                    state_d = S_SEARCH;
                end
            end
            S_SEARCH: begin
                // Keep the candidate bit only if x lies strictly above bp[cand-1].
                if (x_q > bp_at(SEG_BITS'(cand - 1'b1))) begin
                    idx_next = cand;
                end
                idx_d = idx_next;
                if (step_q == '0) begin
                    state_d  = S_DONE;
                    seg_d    = idx_next;
                    x_out_d  = x_q;
                    sat_lo_d = (idx_next == '0);
                    sat_hi_d = &idx_next;
                end else begin
                    step_d = step_q - 1'b1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            idx_q       <= '0;
            step_q      <= '0;
            seg_q       <= '0;
            x_out_q     <= '0;
            sat_lo_q    <= 1'b0;
            sat_hi_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            idx_q       <= idx_d;
            step_q      <= step_d;
            seg_q       <= seg_d;
            x_out_q     <= x_out_d;
            sat_lo_q    <= sat_lo_d;
            sat_hi_q    <= sat_hi_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.seg       = seg_q;
    assign bus.x_out     = x_out_q;
    assign bus.sat_lo    = sat_lo_q;
    assign bus.sat_hi    = sat_hi_q;
endmodule

// File: tb/tb_sig_segment_search.sv
// Directed and random checks of sig_segment_search against a breakpoint-count
// reference model.
module tb_sig_segment_search;
    localparam int unsigned Q        = 12;
    localparam int unsigned N        = 16;
    localparam int unsigned SEG_BITS = 3;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   accept_cyc  = 0;

    sig_segment_search_if #(.N(N), .SEG_BITS(SEG_BITS)) bus ();

    sig_segment_search #(.Q(Q), .N(N), .SEG_BITS(SEG_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Segment = number of breakpoints (-3..3 in Q3.12) strictly below x.
    function automatic int ref_seg(input logic [15:0] xv);
        int xi;
        int c;
        xi = int'($signed(xv));
        c  = 0;
        for (int k = -3; k <= 3; k++) begin
            if (xi > k * 4096) c++;
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [15:0] xv);
        bus.x        = xv;
        bus.in_valid = 1'b1;
        check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        tick();
        accept_cyc   = cyc;
        bus.in_valid = 1'b0;
        bus.x        = 16'($urandom);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.out_valid && lat < 20);
    endtask

    task automatic check_result(input string tag, input logic [15:0] xv, input int lat,
                                input bit chk_lat);
        int e;
        e = ref_seg(xv);
        if (chk_lat) check({tag, "_latency"}, 32'(lat), 32'd3);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_seg"},       32'(bus.seg),       32'(e));
        check({tag, "_sat_lo"},    32'(bus.sat_lo),    32'(e == 0));
        check({tag, "_sat_hi"},    32'(bus.sat_hi),    32'(e == 7));
        check({tag, "_x_out"},     32'(bus.x_out),     32'(xv));
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        tick();
        check("post_handshake_out_valid", 32'(bus.out_valid), 32'd0);
        check("post_handshake_in_ready",  32'(bus.in_ready),  32'd1);
    endtask

    initial begin
        int          lat;
        int          prev_acc;
        logic [15:0] xv;
        logic [15:0] dir_x [5];

        dir_x[0] = 16'h0000;
        dir_x[1] = 16'h0001;
        dir_x[2] = 16'hF000;
        dir_x[3] = 16'h8000;
        dir_x[4] = 16'h7FFF;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_in_ready",  32'(bus.in_ready),  32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_seg",       32'(bus.seg),       32'd0);
        check("reset_x_out",     32'(bus.x_out),     32'd0);
        check("reset_sat_lo",    32'(bus.sat_lo),    32'd0);
        check("reset_sat_hi",    32'(bus.sat_hi),    32'd0);

        // Directed points: zero, just above zero, exact breakpoint, extremes.
        for (int i = 0; i < 5; i++) begin
            accept(dir_x[i]);
            check("search_in_ready", 32'(bus.in_ready), 32'd0);
            wait_result(lat);
            check_result("directed", dir_x[i], lat, 1'b1);
            handshake();
        end
        check("spot_seg_0001", 32'(ref_seg(16'h0001)), 32'd4);

        // Backpressure: result must hold and a new operand must wait.
        xv = 16'h1234;
        bus.out_ready = 1'b0;
        accept(xv);
        wait_result(lat);
        check_result("bp_first", xv, lat, 1'b1);
        bus.in_valid = 1'b1;
        bus.x        = 16'hE800;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_seg",       32'(bus.seg),       32'(ref_seg(xv)));
            check("bp_hold_x_out",     32'(bus.x_out),     32'(xv));
            check("bp_hold_in_ready",  32'(bus.in_ready),  32'd0);
        end
        handshake();
        tick();
        bus.in_valid = 1'b0;
        check("bp_second_taken", 32'(bus.in_ready), 32'd0);
        wait_result(lat);
        check_result("bp_second", 16'hE800, lat, 1'b1);
        handshake();

        // Reset in the second search cycle discards the pending result.
        accept(16'h1000);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_in_ready",  32'(bus.in_ready),  32'd1);
        check("abort_seg",       32'(bus.seg),       32'd0);
        check("abort_x_out",     32'(bus.x_out),     32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_stale", 32'(bus.out_valid), 32'd0);
        end

        // Random sweep, back to back, biased partly toward breakpoint edges.
        bus.out_ready = 1'b1;
        prev_acc = 0;
        for (int i = 0; i < 10000; i++) begin
            if (($urandom % 4) == 0)
                xv = 16'(((int'($urandom_range(6, 0)) - 3) * 4096) + int'($urandom_range(2, 0)) - 1);
            else
                xv = 16'($urandom);
            accept(xv);
            if (i > 0) check("sweep_throughput", 32'(accept_cyc - prev_acc), 32'd5);
            prev_acc = accept_cyc;
            wait_result(lat);
            check_result("sweep", xv, lat, 1'b0);
            tick();
            check("sweep_release", 32'(bus.out_valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
